rd_pixel_packer: RTL and testbench

Read-side consumer of the AsyncFIFO in the pixel path, running in the FIFO's read-clock domain. It pulls 4-bit entries from the FIFO whenever the FIFO is non-empty and packs PACK consecutive entries into one wide pixel word. It presents these words on a valid/ready stream to the scan-out stage and tags the final word of each line.

---
 rtl/rd_pixel_packer_pkg.sv | 16 +
 rtl/pixel_out_queue.sv | 75 +++++++
 rtl/rd_pixel_packer.sv | 115 +++++++++++
 tb/tb_rd_pixel_packer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_pixel_packer_pkg.sv
// Shared constants for the read-side pixel path: FIFO geometry, packing defaults
// and a small helper for sizing counters.
package rd_pixel_packer_pkg;

  localparam int FIFO_DATA_W    = 4;
  localparam int FIFO_DEPTH     = 16;
  localparam int PACK_DEF       = 4;
  localparam int LINE_WORDS_DEF = 160;
  localparam int WORD_W         = FIFO_DATA_W * PACK_DEF;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_out_queue.sv
// Two-entry valid/ready queue with occupancy output. The head register only
// changes on a pop or when the queue is empty, so out_data is stable under stall.
module pixel_out_queue
  import rd_pixel_packer_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         pop;

  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign count     = count_q;
  assign pop       = out_valid && out_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (in_valid) begin
          head_d  = in_data;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (in_valid && pop) begin
          head_d = in_data;
        end else if (in_valid) begin
          tail_d  = in_data;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        // A push into a full queue without a pop is dropped; callers never do it.
        if (pop) begin
          head_d = tail_q;
          if (in_valid) begin
            tail_d = in_data;
          end else begin
            count_d = 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rd_pixel_packer.sv
// Pulls entries from the async FIFO read port, packs PACK of them into one word,
// and streams the words out with an end-of-line tag and a sticky protocol error.
module rd_pixel_packer
  import rd_pixel_packer_pkg::*;
#(
  parameter int DATA_W     = FIFO_DATA_W,
  parameter int PACK       = PACK_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   io_fifo_en,
  input  logic [DATA_W-1:0]      io_fifo_data,
  input  logic                   io_fifo_valid,
  input  logic                   io_fifo_empty,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [DATA_W*PACK-1:0] io_out_data,
  output logic                   io_out_last,
  output logic                   io_err
);

  localparam int POS_W = cnt_width(PACK);
  localparam int IDX_W = cnt_width(LINE_WORDS);
  localparam int SH_W  = DATA_W * (PACK - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(PACK - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LINE_WORDS - 1);

  logic [POS_W-1:0]       issue_pos_q, issue_pos_d;
  logic [POS_W-1:0]       nib_cnt_q, nib_cnt_d;
  logic [SH_W-1:0]        shreg_q, shreg_d;
  logic [IDX_W-1:0]       word_idx_q, word_idx_d;
  logic                   in_flight_q, in_flight_d;
  logic                   skip_q, skip_d;
  logic                   err_q, err_d;
  logic [1:0]             out_count;
  logic                   take;
  logic                   push;
  logic                   pop;
  logic [DATA_W*PACK-1:0] joined;

  // The word-completing read waits for a free queue slot; one read in flight at most.
  assign io_fifo_en = !reset && !io_fifo_empty &&
                      (issue_pos_q != POS_LAST || out_count <= 2'd1);

  // skip_q marks the first cycle after reset, whose returning data is stale.
  assign take   = io_fifo_valid && !skip_q;
  assign joined = {io_fifo_data, shreg_q};
  assign push   = take && (nib_cnt_q == POS_LAST);
  assign pop    = io_out_valid && io_out_ready;

  always_comb begin
    issue_pos_d = issue_pos_q;
    nib_cnt_d   = nib_cnt_q;
    shreg_d     = shreg_q;
    word_idx_d  = word_idx_q;
    in_flight_d = io_fifo_en;
    skip_d      = 1'b0;
    err_d       = err_q | (take && !in_flight_q) | (!io_fifo_valid && in_flight_q);

    if (io_fifo_en) begin
      issue_pos_d = (issue_pos_q == POS_LAST) ? '0 : issue_pos_q + 1'b1;
    end

    if (take) begin
      if (push) begin
        nib_cnt_d = '0;
      end else begin
        nib_cnt_d = nib_cnt_q + 1'b1;
        shreg_d   = joined[DATA_W*PACK-1:DATA_W];
      end
    end

    if (pop) begin
      word_idx_d = (word_idx_q == IDX_LAST) ? '0 : word_idx_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      issue_pos_q <= '0;
      nib_cnt_q   <= '0;
      shreg_q     <= '0;
      word_idx_q  <= '0;
      in_flight_q <= 1'b0;
      skip_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      issue_pos_q <= issue_pos_d;
      nib_cnt_q   <= nib_cnt_d;
      shreg_q     <= shreg_d;
      word_idx_q  <= word_idx_d;
      in_flight_q <= in_flight_d;
      skip_q      <= skip_d;
      err_q       <= err_d;
    end
  end

  pixel_out_queue #(
    .W(DATA_W * PACK)
  ) u_out_queue (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (push),
    .in_data   (joined),
    .out_valid (io_out_valid),
    .out_ready (io_out_ready),
    .out_data  (io_out_data),
    .count     (out_count)
  );

  assign io_out_last = (word_idx_q == IDX_LAST) && io_out_valid;
  assign io_err      = err_q;

endmodule

// File: tb/tb_rd_pixel_packer.sv
// Bench for rd_pixel_packer: a queue-based FIFO emulation, a word-level reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_rd_pixel_packer;
  import rd_pixel_packer_pkg::*;

  localparam int PACK = PACK_DEF;
  localparam int LW   = 2;
  localparam int W    = FIFO_DATA_W;
  localparam int OW   = WORD_W;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset      = 1'b1;
  logic          fifo_en;
  logic [W-1:0]  fifo_data  = '0;
  logic          fifo_valid = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          out_valid;
  logic          out_ready  = 1'b0;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          err;

  rd_pixel_packer #(
    .DATA_W(W), .PACK(PACK), .LINE_WORDS(LW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .io_fifo_en    (fifo_en),
    .io_fifo_data  (fifo_data),
    .io_fifo_valid (fifo_valid),
    .io_fifo_empty (fifo_empty),
    .io_out_valid  (out_valid),
    .io_out_ready  (out_ready),
    .io_out_data   (out_data),
    .io_out_last   (out_last),
    .io_err        (err)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // Commands applied just after the next rising edge.
  bit rst_cmd = 1'b1;
  bit ready_cmd = 1'b0;
  bit force_empty = 1'b0;
  bit inj = 1'b0;
  logic [W-1:0] inj_data = '0;

  // FIFO emulation.
  logic [W-1:0] fifo_q[$];
  bit           req_pend = 1'b0;
  logic [W-1:0] req_data = '0;

  // Reference model state.
  logic [OW-1:0] exp_q[$];
  logic [W-1:0]  partial[$];
  int  issued = 0;
  int  accepted = 0;
  bit  exp_err = 1'b0;
  bit  prev_rst = 1'b1;
  bit  prev_req = 1'b0;

  // Scenario observations.
  int  en_cycles = 0;
  int  first_valid_cyc = -1;
  logic [OW-1:0] popped[$];
  bit  popped_last[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    logic [OW-1:0] word;
    bit take;
    @(posedge clock);
    #1;
    cyc++;
    reset      = rst_cmd;
    out_ready  = ready_cmd;
    fifo_valid = req_pend || inj;
    fifo_data  = inj ? inj_data : req_data;
    fifo_empty = force_empty || (fifo_q.size() == 0);
    inj        = 1'b0;
    @(negedge clock);

    check("en", fifo_en, !reset && !fifo_empty &&
          (((issued % PACK) != PACK - 1) || (exp_q.size() <= 1)));
    check("valid", out_valid, exp_q.size() != 0);
    check("err", err, exp_err);
    if (exp_q.size() != 0) begin
      check("data", out_data, exp_q[0]);
      check("last", out_last, (accepted % LW) == LW - 1);
    end else begin
      check("last_idle", out_last, 0);
    end
    if (reset && prev_rst) check("rst_data", out_data, 0);
    if (fifo_en) en_cycles++;
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

    take = fifo_valid && !reset && !prev_rst;
    if (reset) begin
      exp_q.delete();
      partial.delete();
      issued   = 0;
      accepted = 0;
      exp_err  = 1'b0;
    end else begin
      if (take && !prev_req) exp_err = 1'b1;
      if (!fifo_valid && prev_req) exp_err = 1'b1;
      if (exp_q.size() != 0 && out_ready) begin
        popped.push_back(out_data);
        popped_last.push_back(out_last);
        $display("[TB] cycle %0d word %h last %0b", cyc, out_data, out_last);
        void'(exp_q.pop_front());
        accepted++;
      end
      if (take) begin
        partial.push_back(fifo_data);
        if (partial.size() == PACK) begin
          word = '0;
          for (int i = 0; i < PACK; i++) word |= OW'(partial[i]) << (i * W);
          exp_q.push_back(word);
          partial.delete();
        end
      end
      if (fifo_en && !fifo_empty) issued++;
    end

    req_pend = 1'b0;
    if (fifo_en && !fifo_empty && fifo_q.size() != 0) begin
      req_pend = 1'b1;
      req_data = fifo_q.pop_front();
    end
    prev_req = fifo_en && !fifo_empty;
    prev_rst = reset;
  endtask

  task automatic apply_reset();
    rst_cmd = 1'b1;
    force_empty = 1'b0;
    fifo_q.delete();
    repeat (2) step();
    rst_cmd = 1'b0;
    popped.delete();
    popped_last.delete();
  endtask

  initial begin
    int t0;
    int total;

    // Preloaded 1,2,3,4 with ready high.
    apply_reset();
    ready_cmd = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) fifo_q.push_back(W'(i));
    t0 = cyc + 1;
    en_cycles = 0;
    first_valid_cyc = -1;
    repeat (12) step();
    check("t1_latency", first_valid_cyc - t0, PACK + 1);
    check("t1_en_cycles", en_cycles, 4);
    check("t1_count", popped.size(), 1);
    if (popped.size() >= 1) check("t1_word", popped[0], 16'h4321);

    // Backpressure with 12 entries.
    apply_reset();
    ready_cmd = 1'b0;
    for (int i = 0; i < 12; i++) fifo_q.push_back(W'(i));
    en_cycles = 0;
    repeat (30) step();
    check("t2_en_cycles", en_cycles, 11);
    check("t2_fifo_left", fifo_q.size(), 1);
    check("t2_head_valid", out_valid, 1);
    check("t2_head_data", out_data, 16'h3210);
    ready_cmd = 1'b1;
    repeat (12) step();
    check("t2_count", popped.size(), 3);
    if (popped.size() >= 3) begin
      check("t2_w0", popped[0], 16'h3210);
      check("t2_w1", popped[1], 16'h7654);
      check("t2_w2", popped[2], 16'hBA98);
    end

    // Line tagging with two words per line, five words.
    apply_reset();
    ready_cmd = 1'b1;
    for (int i = 0; i < 20; i++) fifo_q.push_back(W'(i % 16));
    repeat (40) step();
    check("t3_count", popped.size(), 5);
    if (popped.size() >= 5) begin
      for (int k = 0; k < 5; k++) check("t3_last", popped_last[k], (k % 2) == 1);
      check("t3_w4", popped[4], 16'h3210);
    end

    // Empty toggling every cycle with random backpressure.
    apply_reset();
    for (int i = 0; i < 24; i++) fifo_q.push_back(W'($urandom_range(0, 15)));
    for (int c = 0; c < 80; c++) begin
      force_empty = (c % 2) == 0;
      ready_cmd = $urandom_range(0, 1) == 1;
      step();
    end
    force_empty = 1'b0;
    ready_cmd = 1'b1;
    repeat (40) step();
    check("t4_count", popped.size(), 6);
    check("t4_err", err, 0);

    // Reset after 2 of 4 entries, stale valid right after reset.
    apply_reset();
    ready_cmd = 1'b1;
    fifo_q.push_back(4'h1);
    fifo_q.push_back(4'h2);
    repeat (4) step();
    rst_cmd = 1'b1;
    repeat (2) step();
    rst_cmd = 1'b0;
    popped.delete();
    popped_last.delete();
    inj = 1'b1;
    inj_data = 4'hF;
    step();
    for (int i = 5; i <= 8; i++) fifo_q.push_back(W'(i));
    repeat (12) step();
    check("t5_count", popped.size(), 1);
    if (popped.size() >= 1) check("t5_word", popped[0], 16'h8765);
    check("t5_err", err, 0);

    // Spurious valid with no request outstanding.
    apply_reset();
    force_empty = 1'b1;
    repeat (3) step();
    inj = 1'b1;
    inj_data = 4'h0;
    step();
    step();
    check("t6_err_set", err, 1);
    repeat (5) step();
    check("t6_err_held", err, 1);
    apply_reset();
    check("t6_err_cleared", err, 0);

    // Random stress.
    apply_reset();
    total = 0;
    for (int c = 0; c < 300; c++) begin
      force_empty = $urandom_range(0, 9) < 3;
      ready_cmd = $urandom_range(0, 9) < 7;
      if (fifo_q.size() < FIFO_DEPTH && $urandom_range(0, 1) == 1) begin
        fifo_q.push_back(W'($urandom_range(0, 15)));
        total++;
      end
      step();
    end
    force_empty = 1'b0;
    ready_cmd = 1'b1;
    repeat (80) step();
    check("t7_count", popped.size(), total / PACK);
    check("t7_err", err, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
